// File: rtl/phase_clock_ctrl_pkg.sv
// phase_clock_ctrl_pkg
// Shared definitions for the two-phase clock controller: default counter
// width, one-hot state encoding and the config-port address map.
// No ports; imported by phase_clock_ctrl and phase_timer.
package phase_clock_ctrl_pkg;

  // Default width of the length registers and the phase down-counter.
  localparam int DEF_CNT_W = 9;

  // Bit position of each state inside the one-hot state vector.
  localparam int IDX_IDLE = 0;
  localparam int IDX_P1   = 1;
  localparam int IDX_G1   = 2;
  localparam int IDX_P2   = 3;
  localparam int IDX_G2   = 4;

  // One-hot states. phi_1 and phi_2 are taken straight from the P1 and P2 bits.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_P1   = 5'b00010,
    ST_G1   = 5'b00100,
    ST_P2   = 5'b01000,
    ST_G2   = 5'b10000
  } state_t;

  // Config-port addresses. Address 3 is a no-op.
  localparam logic [1:0] ADDR_P1  = 2'd0;
  localparam logic [1:0] ADDR_GAP = 2'd1;
  localparam logic [1:0] ADDR_P2  = 2'd2;

endpackage

// File: rtl/phase_clock_ctrl_timer.sv
// phase_timer
// Loadable down-counter that times each non-IDLE phase. It holds at zero
// once it gets there, and zero_o tells the FSM that the phase is complete.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   load_i       load load_val_i on this edge (this wins over counting)
//   load_val_i   value to load: phase length minus one
//   zero_o       high while the count is zero
module phase_timer
  import phase_clock_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/phase_clock_ctrl.sv
// phase_clock_ctrl
// Two-phase non-overlapping clock generator for the CPU core. It runs the
// sequence P1 -> G1 -> P2 -> G2. It can free-run, execute a single step, or
// halt cleanly at a cycle boundary. The phase and gap lengths can be set at
// runtime.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   cfg_we/addr/wdata     write port for the P1, GAP and P2 length registers
//   run                   level input: free-run while high
//   step_req              pulse input: run one full cycle from IDLE
//   step_ack              one-cycle pulse when a stepped cycle ends
//   halted                high while in IDLE
//   phi_1, phi_2          the two phase clocks, each taken from one state flop
//   cyc_count             number of completed cycles, modulo 2^32
module phase_clock_ctrl
  import phase_clock_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_P1  = 100,
  parameter int DEF_GAP = 100,
  parameter int DEF_P2  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic             halted,
  output logic             phi_1,
  output logic             phi_2,
  output logic [31:0]      cyc_count
);

  // A stored length of L gives a counter load value of L-1. A length of 0
  // is treated as 1.
  function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_p1_q, len_gap_q, len_p2_q;
  logic [CNT_W-1:0] sh_gap_q, sh_p2_q;
  logic [CNT_W-1:0] p1_fwd, gap_fwd, p2_fwd;
  logic             step_q, step_set, step_clr;
  logic             ack_q, ack_d;
  logic             halted_q;
  logic [31:0]      cyc_q;
  logic             cyc_inc;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             enter_p1;

  // These are the length values after any write on this edge has been
  // applied. A write that lands on the same edge as P1 entry is therefore
  // used by the cycle that starts on that edge.
  assign p1_fwd  = (cfg_we && cfg_addr == ADDR_P1)  ? cfg_wdata : len_p1_q;
  assign gap_fwd = (cfg_we && cfg_addr == ADDR_GAP) ? cfg_wdata : len_gap_q;
  assign p2_fwd  = (cfg_we && cfg_addr == ADDR_P2)  ? cfg_wdata : len_p2_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state logic. Each state moves on when the timer reaches zero, and
  // the timer is reloaded for the state being entered. Run has priority over
  // step in IDLE. A step is only ever accepted from IDLE.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    step_set = 1'b0;
    step_clr = 1'b0;
    ack_d    = 1'b0;
    cyc_inc  = 1'b0;
    enter_p1 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run || step_req) begin
          state_d  = ST_P1;
          enter_p1 = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = len_to_load(p1_fwd);
          step_set = !run;
        end
      end
      ST_P1: begin
        if (tmr_zero) begin
          state_d  = ST_G1;
          tmr_load = 1'b1;
          tmr_val  = len_to_load(sh_gap_q);
        end
      end
      ST_G1: begin
        if (tmr_zero) begin
          state_d  = ST_P2;
          tmr_load = 1'b1;
          tmr_val  = len_to_load(sh_p2_q);
        end
      end
      ST_P2: begin
        if (tmr_zero) begin
          state_d  = ST_G2;
          tmr_load = 1'b1;
          tmr_val  = len_to_load(sh_gap_q);
        end
      end
      ST_G2: begin
        if (tmr_zero) begin
          cyc_inc = 1'b1;
          if (run && !step_q) begin
            state_d  = ST_P1;
            enter_p1 = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = len_to_load(p1_fwd);
          end else begin
            state_d  = ST_IDLE;
            ack_d    = step_q;
            step_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers. The shadow lengths are captured on each P1
  // entry so that the whole cycle uses one consistent set of lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_p1_q  <= CNT_W'(DEF_P1);
      len_gap_q <= CNT_W'(DEF_GAP);
      len_p2_q  <= CNT_W'(DEF_P2);
      sh_gap_q  <= CNT_W'(DEF_GAP);
      sh_p2_q   <= CNT_W'(DEF_P2);
      step_q    <= 1'b0;
      ack_q     <= 1'b0;
      halted_q  <= 1'b1;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_p1_q  <= p1_fwd;
      len_gap_q <= gap_fwd;
      len_p2_q  <= p2_fwd;
      if (enter_p1) begin
        sh_gap_q <= gap_fwd;
        sh_p2_q  <= p2_fwd;
      end
      if (step_set) begin
        step_q <= 1'b1;
      end else if (step_clr) begin
        step_q <= 1'b0;
      end
      ack_q    <= ack_d;
      halted_q <= (state_d == ST_IDLE);
      if (cyc_inc) begin
        cyc_q <= cyc_q + 32'd1;
      end
    end
  end

  assign phi_1     = state_q[IDX_P1];
  assign phi_2     = state_q[IDX_P2];
  assign step_ack  = ack_q;
  assign halted    = halted_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_phase_clock_ctrl.sv
// tb_phase_clock_ctrl
// Directed bench for phase_clock_ctrl. Every expected value is worked out by
// hand from the length settings. Inputs are driven and outputs are sampled
// on the falling edge.
module tb_phase_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [8:0]  cfg_wdata = 9'd0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic        step_ack, halted, phi_1, phi_2;
  logic [31:0] cyc_count;

  int compared = 0;
  int mismatched = 0;
  int overlapCnt = 0;
  int n;

  phase_clock_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .run       (run),
    .step_req  (step_req),
    .step_ack  (step_ack),
    .halted    (halted),
    .phi_1     (phi_1),
    .phi_2     (phi_2),
    .cyc_count (cyc_count)
  );

  always #5 clk = ~clk;

  // Count every sample at which both phases are high. The count must stay zero.
  always @(negedge clk) begin
    if (phi_1 && phi_2) overlapCnt++;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic we,
                               input logic [1:0] a, input logic [8:0] d);
    run = r;
    step_req = s;
    cfg_we = we;
    cfg_addr = a;
    cfg_wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count the falling edges for which {phi_1,phi_2} stays at the given code.
  // The count is capped so that a stuck output cannot hang the run.
  task automatic countWhile(input logic [1:0] code, output int cnt);
    cnt = 0;
    while ({phi_1, phi_2} === code && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Count the falling edges until halted goes high, with a cap.
  task automatic waitHalted(output int cnt);
    cnt = 0;
    while (halted !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Check the reset values, then free-run with the default lengths.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_phi1", phi_1, 0);
    checkOutput("rst_phi2", phi_2, 0);
    checkOutput("rst_ack", step_ack, 0);
    checkOutput("rst_halted", halted, 1);
    checkOutput("rst_cyc", cyc_count, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_p1_start", phi_1, 1);
    countWhile(2'b10, n); checkOutput("t1_p1_len", n, 100);
    countWhile(2'b00, n); checkOutput("t1_g1_len", n, 100);
    countWhile(2'b01, n); checkOutput("t1_p2_len", n, 100);
    countWhile(2'b00, n); checkOutput("t1_g2_len", n, 100);
    checkOutput("t1_period_phi1", phi_1, 1);
    checkOutput("t1_cyc", cyc_count, 1);
    applyStimulus(0, 0, 0, 0, 0);
    waitHalted(n);
    checkOutput("t1_halt_wait", n, 400);
    checkOutput("t1_halt_cyc", cyc_count, 2);

    // Set short lengths 3/1/5 and free-run.
    applyStimulus(0, 0, 1, 2'd0, 9'd3); @(negedge clk);
    applyStimulus(0, 0, 1, 2'd1, 9'd1); @(negedge clk);
    applyStimulus(0, 0, 1, 2'd2, 9'd5); @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    countWhile(2'b10, n); checkOutput("t2_p1_len", n, 3);
    countWhile(2'b00, n); checkOutput("t2_g1_len", n, 1);
    countWhile(2'b01, n); checkOutput("t2_p2_len", n, 5);
    countWhile(2'b00, n); checkOutput("t2_g2_len", n, 1);
    checkOutput("t2_cyc1", cyc_count, 3);
    repeat (30) @(negedge clk);
    checkOutput("t2_cyc4", cyc_count, 6);
    checkOutput("t2_period_phi1", phi_1, 1);

    // Drop run in the middle of P2. P2 and G2 must still finish in full.
    repeat (5) @(negedge clk);
    checkOutput("t3_in_p2", phi_2, 1);
    applyStimulus(0, 0, 0, 0, 0);
    countWhile(2'b01, n); checkOutput("t3_p2_rest", n, 4);
    waitHalted(n); checkOutput("t3_g2_len", n, 1);
    checkOutput("t3_cyc", cyc_count, 7);
    repeat (20) @(negedge clk);
    checkOutput("t3_phases_low", {phi_1, phi_2}, 0);
    checkOutput("t3_still_halted", halted, 1);

    // Single step. A second step_req sent during P1 must be ignored.
    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_p1_start", phi_1, 1);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    countWhile(2'b10, n); checkOutput("t4_p1_rest", n, 1);
    countWhile(2'b00, n); checkOutput("t4_g1_len", n, 1);
    countWhile(2'b01, n); checkOutput("t4_p2_len", n, 5);
    checkOutput("t4_ack_early", step_ack, 0);
    waitHalted(n); checkOutput("t4_g2_len", n, 1);
    checkOutput("t4_ack", step_ack, 1);
    checkOutput("t4_cyc", cyc_count, 8);
    @(negedge clk);
    checkOutput("t4_ack_drop", step_ack, 0);
    checkOutput("t4_no_restart", halted, 1);

    // Set GAP to 0, then assert run and step together (run wins). Write P1=7
    // during G1; the current cycle keeps P1=3.
    applyStimulus(0, 0, 1, 2'd1, 9'd0); @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0); @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    countWhile(2'b10, n); checkOutput("t5_p1_len", n, 3);
    checkOutput("t5_in_g1", {phi_1, phi_2}, 0);
    applyStimulus(1, 0, 1, 2'd0, 9'd7); @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5_gap0_p2", phi_2, 1);
    countWhile(2'b01, n); checkOutput("t5_p2_len", n, 5);
    countWhile(2'b00, n); checkOutput("t5_g2_len", n, 1);
    checkOutput("t5_no_ack", step_ack, 0);
    countWhile(2'b10, n); checkOutput("t5_p1_new", n, 7);
    countWhile(2'b00, n); checkOutput("t5_g1_len", n, 1);
    countWhile(2'b01, n); checkOutput("t5_p2_len2", n, 5);
    countWhile(2'b00, n); checkOutput("t5_g2_len2", n, 1);
    checkOutput("t5_cyc", cyc_count, 10);
    checkOutput("t5_in_p1", phi_1, 1);

    // Assert reset between clock edges in P1. phi_1 must drop before the
    // next rising edge.
    #2 rst = 1'b1;
    #1 checkOutput("t6_async_phi1", phi_1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_halted", halted, 1);
    checkOutput("t6_cyc", cyc_count, 0);
    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    countWhile(2'b10, n); checkOutput("t6_def_p1", n, 100);
    countWhile(2'b00, n); checkOutput("t6_def_g1", n, 100);
    countWhile(2'b01, n); checkOutput("t6_def_p2", n, 100);
    waitHalted(n); checkOutput("t6_def_g2", n, 100);
    checkOutput("t6_ack", step_ack, 1);

    checkOutput("no_overlap", overlapCnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
